// File: rtl/fetch_align_queue_pkg.sv
// Shared types for the fetch alignment queue: fetch error codes, the
// half-word queue entry and the "is this a real fetch error" test.
package fetch_align_queue_pkg;

  localparam logic [2:0] FETCH_VALID = 3'b000;
  localparam logic [2:0] FETCH_INCER = 3'b001;
  localparam logic [2:0] FETCH_BSERR = 3'b010;
  localparam logic [2:0] FETCH_PMERR = 3'b011;

  // wbound marks the upper half of a fetch word: the entry after it comes
  // from a different fetch word.
  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  err;
    logic        pred;
    logic        wbound;
  } hw_entry;

  function automatic logic is_fetch_err(input logic [2:0] err);
    return (err != FETCH_VALID) && (err != FETCH_INCER);
  endfunction

endpackage

// File: rtl/halfword_fifo.sv
// Circular half-word store with push-1/push-2 and pop-1/pop-2 ports;
// exposes the head entry and the one after it.
module halfword_fifo
  import fetch_align_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        push,
  input  logic                        push_two,
  input  hw_entry                     push_first,
  input  hw_entry                     push_second,
  input  logic                        pop,
  input  logic                        pop_two,
  output hw_entry                     head,
  output hw_entry                     head_next,
  output logic [$clog2(2*DEPTH):0]    count
);

  localparam int ENTRIES = 2 * DEPTH;
  localparam int PW      = $clog2(ENTRIES);
  localparam int CW      = PW + 1;

  hw_entry         mem [ENTRIES];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [CW-1:0]   push_num;
  logic [CW-1:0]   pop_num;

  always_comb begin
    push_num = '0;
    pop_num  = '0;
    if (push) push_num = push_two ? CW'(2) : CW'(1);
    if (pop)  pop_num  = pop_two  ? CW'(2) : CW'(1);
  end

  // Pointers wrap naturally because the entry count is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      tail_ptr <= tail_ptr + push_num[PW-1:0];
      head_ptr <= head_ptr + pop_num[PW-1:0];
      count    <= count + push_num - pop_num;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[tail_ptr] <= push_first;
      if (push_two) mem[tail_ptr + PW'(1)] <= push_second;
    end
  end

  assign head      = mem[head_ptr];
  assign head_next = mem[head_ptr + PW'(1)];

endmodule

// File: rtl/fetch_align_queue.sv
// Re-aligns a stream of 32-bit fetch words into RVC/RVI instructions with
// their PC, merged fetch error and prediction tags for the ID stage.
module fetch_align_queue
  import fetch_align_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      s_clk_i,
  input  logic                      s_resetn_i,
  input  logic                      s_flush_i,
  input  logic [31:0]               s_flush_addr_i,
  input  logic                      s_fetch_valid_i,
  input  logic [31:0]               s_fetch_data_i,
  input  logic [2:0]                s_fetch_error_i,
  input  logic                      s_fetch_pred_i,
  output logic                      s_fetch_ready_o,
  output logic                      s_id_valid_o,
  input  logic                      s_id_ready_i,
  output logic [31:0]               s_id_instr_o,
  output logic [31:0]               s_id_pc_o,
  output logic                      s_id_rvc_o,
  output logic [2:0]                s_id_error_o,
  output logic                      s_id_pred_o,
  output logic                      s_id_align_error_o,
  output logic [$clog2(2*DEPTH):0]  s_count_o
);

  localparam int CW = $clog2(2*DEPTH) + 1;

  logic [31:0] pc;
  logic        skip;
  hw_entry     head;
  hw_entry     head_next;
  hw_entry     push_first;
  hw_entry     push_second;
  logic        push;
  logic        pop;
  logic        take_two;
  logic        head_rvc;
  logic        head_bad;
  logic        unused_flush_bit;

  assign unused_flush_bit = s_flush_addr_i[0];

  // Ready depends only on the registered count so ID backpressure never
  // reaches the fetch side combinationally.
  assign s_fetch_ready_o = (s_count_o <= CW'(2*DEPTH - 2));
  assign push            = s_fetch_valid_i & s_fetch_ready_o & ~s_flush_i;

  always_comb begin
    push_first  = '{data: s_fetch_data_i[15:0],  err: s_fetch_error_i,
                    pred: s_fetch_pred_i, wbound: 1'b0};
    push_second = '{data: s_fetch_data_i[31:16], err: s_fetch_error_i,
                    pred: s_fetch_pred_i, wbound: 1'b1};
    if (skip) push_first = push_second;
  end

  halfword_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (s_clk_i),
    .rst_n       (s_resetn_i),
    .clear       (s_flush_i),
    .push        (push),
    .push_two    (~skip),
    .push_first  (push_first),
    .push_second (push_second),
    .pop         (pop),
    .pop_two     (take_two),
    .head        (head),
    .head_next   (head_next),
    .count       (s_count_o)
  );

  // A lone erroneous half-word is released alone so the error is not
  // stuck behind a second half that may never arrive.
  always_comb begin
    head_rvc           = (head.data[1:0] != 2'b11);
    head_bad           = is_fetch_err(head.err);
    take_two           = ~head_rvc & (s_count_o >= CW'(2));
    s_id_valid_o       = (s_count_o != '0) & (head_rvc | (s_count_o >= CW'(2)) | head_bad)
                         & ~s_flush_i;
    pop                = s_id_valid_o & s_id_ready_i;
    s_id_pc_o          = pc;
    s_id_instr_o       = '0;
    s_id_rvc_o         = 1'b0;
    s_id_error_o       = FETCH_VALID;
    s_id_pred_o        = 1'b0;
    s_id_align_error_o = 1'b0;
    if (s_id_valid_o) begin
      s_id_instr_o = take_two ? {head_next.data, head.data} : {16'h0000, head.data};
      s_id_rvc_o   = head_rvc;
      if (head_bad)
        s_id_error_o = head.err;
      else if (take_two && is_fetch_err(head_next.err))
        s_id_error_o = head_next.err;
      else
        s_id_error_o = head.err;
      s_id_pred_o        = take_two ? head_next.pred : head.pred;
      s_id_align_error_o = take_two & head.pred & head.wbound;
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      pc   <= RESET_PC;
      skip <= RESET_PC[1];
    end else if (s_flush_i) begin
      pc   <= {s_flush_addr_i[31:1], 1'b0};
      skip <= s_flush_addr_i[1];
    end else begin
      if (pop)  pc   <= pc + (take_two ? 32'd4 : 32'd2);
      if (push) skip <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Scoreboard bench for fetch_align_queue: directed fetch words with
// hand-computed expected instructions checked by an independent monitor.
module tb_fetch_align_queue;
  import fetch_align_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rvc;
    logic [2:0]  err;
    logic        pred;
    logic        align;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      s_resetn_i;
  logic                      s_flush_i;
  logic [31:0]               s_flush_addr_i;
  logic                      s_fetch_valid_i;
  logic [31:0]               s_fetch_data_i;
  logic [2:0]                s_fetch_error_i;
  logic                      s_fetch_pred_i;
  logic                      s_fetch_ready_o;
  logic                      s_id_valid_o;
  logic                      s_id_ready_i;
  logic [31:0]               s_id_instr_o;
  logic [31:0]               s_id_pc_o;
  logic                      s_id_rvc_o;
  logic [2:0]                s_id_error_o;
  logic                      s_id_pred_o;
  logic                      s_id_align_error_o;
  logic [$clog2(2*DEPTH):0]  s_count_o;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_align_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .s_clk_i            (clk),
    .s_resetn_i         (s_resetn_i),
    .s_flush_i          (s_flush_i),
    .s_flush_addr_i     (s_flush_addr_i),
    .s_fetch_valid_i    (s_fetch_valid_i),
    .s_fetch_data_i     (s_fetch_data_i),
    .s_fetch_error_i    (s_fetch_error_i),
    .s_fetch_pred_i     (s_fetch_pred_i),
    .s_fetch_ready_o    (s_fetch_ready_o),
    .s_id_valid_o       (s_id_valid_o),
    .s_id_ready_i       (s_id_ready_i),
    .s_id_instr_o       (s_id_instr_o),
    .s_id_pc_o          (s_id_pc_o),
    .s_id_rvc_o         (s_id_rvc_o),
    .s_id_error_o       (s_id_error_o),
    .s_id_pred_o        (s_id_pred_o),
    .s_id_align_error_o (s_id_align_error_o),
    .s_count_o          (s_count_o)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expect_instr(input logic [31:0] instr, input logic [31:0] pc,
                              input logic rvc, input logic [2:0] err,
                              input logic pred, input logic align);
    exp_t e;
    e = '{instr: instr, pc: pc, rvc: rvc, err: err, pred: pred, align: align};
    sb.push_back(e);
  endtask

  // Monitor: compares every accepted ID transfer against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (s_resetn_i && s_id_valid_o && s_id_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: instr 0x%08h pc 0x%08h, none expected",
                   s_id_instr_o, s_id_pc_o);
        end else begin
          e = sb.pop_front();
          check_output("instr", s_id_instr_o, e.instr);
          check_output("pc", s_id_pc_o, e.pc);
          check_output("rvc", 32'(s_id_rvc_o), 32'(e.rvc));
          check_output("error", 32'(s_id_error_o), 32'(e.err));
          check_output("pred", 32'(s_id_pred_o), 32'(e.pred));
          check_output("align_error", 32'(s_id_align_error_o), 32'(e.align));
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] data, input logic [2:0] err,
                                input logic pred);
    int waited = 0;
    s_fetch_valid_i = 1'b1;
    s_fetch_data_i  = data;
    s_fetch_error_i = err;
    s_fetch_pred_i  = pred;
    @(negedge clk);
    while (!s_fetch_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!s_fetch_ready_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: ready 0, required 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    s_fetch_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d pending, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_resetn_i = 1'b0;
    #2;
    @(posedge clk);
    #1;
    s_resetn_i = 1'b1;
  endtask

  task automatic do_flush(input logic [31:0] addr);
    s_flush_i      = 1'b1;
    s_flush_addr_i = addr;
    @(posedge clk);
    #1;
    s_flush_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    s_resetn_i      = 1'b0;
    s_flush_i       = 1'b0;
    s_flush_addr_i  = '0;
    s_fetch_valid_i = 1'b0;
    s_fetch_data_i  = '0;
    s_fetch_error_i = FETCH_VALID;
    s_fetch_pred_i  = 1'b0;
    s_id_ready_i    = 1'b1;
    #2;
    check_output("reset_valid", 32'(s_id_valid_o), 32'd0);
    check_output("reset_count", 32'(s_count_o), 32'd0);
    check_output("reset_ready", 32'(s_fetch_ready_o), 32'd1);
    check_output("reset_instr", s_id_instr_o, 32'd0);
    check_output("reset_error", 32'(s_id_error_o), 32'(FETCH_VALID));
    check_output("reset_pred_align", 32'({s_id_pred_o, s_id_align_error_o, s_id_rvc_o}), 32'd0);
    @(posedge clk);
    #1;
    s_resetn_i = 1'b1;

    // Two compressed nops in one word.
    expect_instr(32'h0000_0001, 32'h0, 1'b1, 3'b000, 1'b0, 1'b0);
    expect_instr(32'h0000_0001, 32'h2, 1'b1, 3'b000, 1'b0, 1'b0);
    apply_stimulus(32'h0001_0001, 3'b000, 1'b0);
    wait_drain();
    check_output("empty_valid", 32'(s_id_valid_o), 32'd0);
    check_output("empty_count", 32'(s_count_o), 32'd0);

    // 32-bit instruction straddling two fetch words.
    do_reset();
    expect_instr(32'h0000_0001, 32'h0, 1'b1, 3'b000, 1'b0, 1'b0);
    expect_instr(32'h0000_0013, 32'h2, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_instr(32'h0000_0000, 32'h6, 1'b1, 3'b000, 1'b0, 1'b0);
    apply_stimulus(32'h0013_0001, 3'b000, 1'b0);
    apply_stimulus(32'h0000_0000, 3'b000, 1'b0);
    wait_drain();

    // Flush to a half-word address drops the lower half of the next word.
    do_flush(32'h0000_0102);
    expect_instr(32'h0000_0093, 32'h102, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_instr(32'h0000_0000, 32'h106, 1'b1, 3'b000, 1'b0, 1'b0);
    apply_stimulus(32'h0093_0001, 3'b000, 1'b0);
    apply_stimulus(32'h0000_0000, 3'b000, 1'b0);
    wait_drain();

    // Fill to capacity with ID stalled, then release one instruction.
    do_reset();
    s_id_ready_i = 1'b0;
    for (int i = 0; i < 5; i++)
      expect_instr(32'h0000_0013, 32'(4 * i), 1'b0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      apply_stimulus(32'h0000_0013, 3'b000, 1'b0);
    check_output("full_count", 32'(s_count_o), 32'd8);
    check_output("full_ready", 32'(s_fetch_ready_o), 32'd0);
    s_fetch_valid_i = 1'b1;
    s_fetch_data_i  = 32'h0000_0013;
    s_fetch_error_i = 3'b000;
    s_fetch_pred_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("full_no_accept", 32'(s_count_o), 32'd8);
    s_id_ready_i = 1'b1;
    @(posedge clk);
    #1;
    s_id_ready_i = 1'b0;
    check_output("after_pop_count", 32'(s_count_o), 32'd6);
    check_output("after_pop_ready", 32'(s_fetch_ready_o), 32'd1);
    @(posedge clk);
    #1;
    s_fetch_valid_i = 1'b0;
    check_output("refill_count", 32'(s_count_o), 32'd8);
    s_id_ready_i = 1'b1;
    wait_drain();
    check_output("drained_count", 32'(s_count_o), 32'd0);

    // Error merge from the second half, then a lone erroneous half-word.
    do_reset();
    expect_instr(32'h0000_0001, 32'h0, 1'b1, 3'b000, 1'b0, 1'b0);
    expect_instr(32'h0000_0013, 32'h2, 1'b0, 3'b101, 1'b0, 1'b0);
    expect_instr(32'h0000_0000, 32'h6, 1'b1, 3'b101, 1'b0, 1'b0);
    apply_stimulus(32'h0013_0001, 3'b000, 1'b0);
    apply_stimulus(32'h0000_0000, 3'b101, 1'b0);
    wait_drain();
    do_flush(32'h0000_0002);
    expect_instr(32'h0000_0013, 32'h2, 1'b0, 3'b101, 1'b0, 1'b0);
    apply_stimulus(32'h0013_0000, 3'b101, 1'b0);
    wait_drain();

    // Prediction on the first half of a word-straddling 32-bit instruction.
    do_reset();
    expect_instr(32'h0000_0001, 32'h0, 1'b1, 3'b000, 1'b1, 1'b0);
    expect_instr(32'h0000_0013, 32'h2, 1'b0, 3'b000, 1'b0, 1'b1);
    expect_instr(32'h0000_0000, 32'h6, 1'b1, 3'b000, 1'b0, 1'b0);
    apply_stimulus(32'h0013_0001, 3'b000, 1'b1);
    apply_stimulus(32'h0000_0000, 3'b000, 1'b0);
    wait_drain();

    // Flush colliding with a push and a pop in the same cycle.
    s_id_ready_i = 1'b0;
    apply_stimulus(32'h0001_0001, 3'b000, 1'b0);
    check_output("pre_flush_count", 32'(s_count_o), 32'd2);
    check_output("pre_flush_valid", 32'(s_id_valid_o), 32'd1);
    s_id_ready_i    = 1'b1;
    s_fetch_valid_i = 1'b1;
    s_fetch_data_i  = 32'h0000_0013;
    s_flush_i       = 1'b1;
    s_flush_addr_i  = 32'h0;
    #1;
    check_output("flush_cycle_valid", 32'(s_id_valid_o), 32'd0);
    @(posedge clk);
    #1;
    s_flush_i       = 1'b0;
    s_fetch_valid_i = 1'b0;
    check_output("post_flush_count", 32'(s_count_o), 32'd0);
    check_output("post_flush_valid", 32'(s_id_valid_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_left: %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
